// File: rtl/bsg_manycore_host_responder_pkg.sv
// Shared types and constants for the host-endpoint responder.
// The address map and the unmapped-load fill pattern live here.
package bsg_manycore_host_responder_pkg;

  typedef enum logic [1:0] {
    e_load  = 2'b00,
    e_store = 2'b01
  } op_e;

  localparam logic [31:0] STDOUT_ADDR  = 32'h0000_1000;
  localparam logic [31:0] FINISH_ADDR  = 32'h0000_1001;
  localparam logic [31:0] FAIL_ADDR    = 32'h0000_1002;
  localparam logic [31:0] SCRATCH_ADDR = 32'h0000_1003;
  localparam logic [31:0] DEFAULT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bsg_manycore_host_responder_if.sv
// Request/response bundle between the manycore network and the host responder.
// slave is the responder side, master is the network (tile) side.
interface bsg_manycore_host_responder_if #(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int reg_id_width_p = 5
) ();

  logic                        req_v_i;
  logic                        req_ready_o;
  logic [1:0]                  req_op_i;
  logic [addr_width_p-1:0]     req_addr_i;
  logic [data_width_p-1:0]     req_data_i;
  logic [data_width_p/8-1:0]   req_mask_i;
  logic [reg_id_width_p-1:0]   req_reg_id_i;
  logic [x_cord_width_p-1:0]   req_src_x_i;
  logic [y_cord_width_p-1:0]   req_src_y_i;

  logic                        resp_v_o;
  logic                        resp_ready_i;
  logic                        resp_load_o;
  logic [data_width_p-1:0]     resp_data_o;
  logic [reg_id_width_p-1:0]   resp_reg_id_o;
  logic [x_cord_width_p-1:0]   resp_dest_x_o;
  logic [y_cord_width_p-1:0]   resp_dest_y_o;

  modport slave (
    input  req_v_i, req_op_i, req_addr_i, req_data_i, req_mask_i,
           req_reg_id_i, req_src_x_i, req_src_y_i, resp_ready_i,
    output req_ready_o, resp_v_o, resp_load_o, resp_data_o,
           resp_reg_id_o, resp_dest_x_o, resp_dest_y_o
  );

  modport master (
    output req_v_i, req_op_i, req_addr_i, req_data_i, req_mask_i,
           req_reg_id_i, req_src_x_i, req_src_y_i, resp_ready_i,
    input  req_ready_o, resp_v_o, resp_load_o, resp_data_o,
           resp_reg_id_o, resp_dest_x_o, resp_dest_y_o
  );

endinterface

// File: rtl/bsg_manycore_host_responder_fifo.sv
// Small circular-buffer FIFO buffering stdout characters.
// A push is refused while full, even if a pop happens in the same cycle.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p + 1);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wr_ptr;
  logic [ptr_w_lp-1:0] r_rd_ptr;
  logic [cnt_w_lp-1:0] r_count;
  logic                w_push;
  logic                w_pop;

  function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
    if (p == ptr_w_lp'(els_p - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = p + ptr_w_lp'(1);
    end
  endfunction

  assign full_o = (r_count == cnt_w_lp'(els_p));
  assign v_o    = (r_count != '0);
  assign data_o = r_mem[r_rd_ptr];
  assign w_push = v_i & ~full_o;
  assign w_pop  = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + cnt_w_lp'(1);
        2'b01:   r_count <= r_count - cnt_w_lp'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule

// File: rtl/bsg_manycore_host_responder.sv
// Host-endpoint responder: decodes ROM/stdout/finish/fail/scratch requests
// and returns exactly one response per accepted request from a holding register.
module bsg_manycore_host_responder
  import bsg_manycore_host_responder_pkg::*;
#(
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 28,
  parameter int x_cord_width_p = 7,
  parameter int y_cord_width_p = 7,
  parameter int reg_id_width_p = 5,
  parameter int rom_els_p      = 16,
  parameter logic [rom_els_p*data_width_p-1:0] rom_arr_p = '0,
  parameter int stdout_els_p   = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  bsg_manycore_host_responder_if.slave host_if,
  output logic                    char_v_o,
  output logic [7:0]              char_o,
  input  logic                    char_ready_i,
  output logic                    finish_v_o,
  output logic                    fail_v_o,
  output logic [data_width_p-1:0] exit_data_o,
  output logic                    err_o
);

  localparam int rom_idx_w_lp = (rom_els_p > 1) ? $clog2(rom_els_p) : 1;

  logic                      w_is_load, w_is_store;
  logic                      w_is_rom, w_is_stdout, w_is_finish, w_is_fail, w_is_scratch;
  logic                      w_mapped, w_stdout_store, w_fifo_full, w_accept;
  logic [rom_idx_w_lp-1:0]   w_rom_idx;
  logic [data_width_p-1:0]   w_rom_word, w_load_data;

  logic                      r_resp_v, r_resp_load;
  logic [data_width_p-1:0]   r_resp_data;
  logic [reg_id_width_p-1:0] r_resp_reg_id;
  logic [x_cord_width_p-1:0] r_resp_dest_x;
  logic [y_cord_width_p-1:0] r_resp_dest_y;
  logic [data_width_p-1:0]   r_scratch, r_exit_data;
  logic                      r_finish_v, r_fail_v, r_err;

  assign w_is_load    = (host_if.req_op_i == e_load);
  assign w_is_store   = (host_if.req_op_i == e_store);
  assign w_is_rom     = (host_if.req_addr_i < addr_width_p'(rom_els_p));
  assign w_is_stdout  = (host_if.req_addr_i == addr_width_p'(STDOUT_ADDR));
  assign w_is_finish  = (host_if.req_addr_i == addr_width_p'(FINISH_ADDR));
  assign w_is_fail    = (host_if.req_addr_i == addr_width_p'(FAIL_ADDR));
  assign w_is_scratch = (host_if.req_addr_i == addr_width_p'(SCRATCH_ADDR));
  assign w_mapped     = w_is_rom | w_is_stdout | w_is_finish | w_is_fail | w_is_scratch;

  assign w_rom_idx  = host_if.req_addr_i[rom_idx_w_lp-1:0];
  assign w_rom_word = rom_arr_p[int'(w_rom_idx)*data_width_p +: data_width_p];

  // Only a stdout store cares about FIFO space; everything else waits on the response slot.
  assign w_stdout_store      = w_is_store & w_is_stdout;
  assign host_if.req_ready_o = (~r_resp_v | host_if.resp_ready_i) & ~(w_stdout_store & w_fifo_full);
  assign w_accept            = host_if.req_v_i & host_if.req_ready_o;

  // Load data selection by address region.
  always_comb begin
    w_load_data = '0;
    if (w_is_rom) begin
      w_load_data = w_rom_word;
    end else if (w_is_scratch) begin
      w_load_data = r_scratch;
    end else if (w_is_stdout | w_is_finish | w_is_fail) begin
      w_load_data = '0;
    end else begin
      w_load_data = data_width_p'(DEFAULT_DATA);
    end
  end

  // Single-entry response holding register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_resp_v      <= 1'b0;
      r_resp_load   <= 1'b0;
      r_resp_data   <= '0;
      r_resp_reg_id <= '0;
      r_resp_dest_x <= '0;
      r_resp_dest_y <= '0;
    end else if (w_accept) begin
      r_resp_v      <= 1'b1;
      r_resp_load   <= w_is_load;
      r_resp_data   <= w_is_load ? w_load_data : '0;
      r_resp_reg_id <= host_if.req_reg_id_i;
      r_resp_dest_x <= host_if.req_src_x_i;
      r_resp_dest_y <= host_if.req_src_y_i;
    end else if (host_if.resp_ready_i) begin
      r_resp_v      <= 1'b0;
    end
  end

  // Store side effects: scratch, exit pulses/data, sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_scratch   <= '0;
      r_exit_data <= '0;
      r_finish_v  <= 1'b0;
      r_fail_v    <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_finish_v <= w_accept & w_is_store & w_is_finish;
      r_fail_v   <= w_accept & w_is_store & w_is_fail;
      if (w_accept & w_is_store & (w_is_finish | w_is_fail)) begin
        r_exit_data <= host_if.req_data_i;
      end
      if (w_accept & w_is_store & w_is_scratch) begin
        for (int b = 0; b < data_width_p/8; b++) begin
          if (host_if.req_mask_i[b]) r_scratch[8*b +: 8] <= host_if.req_data_i[8*b +: 8];
        end
      end
      if (w_accept & ~(w_mapped & (w_is_load | w_is_store))) begin
        r_err <= 1'b1;
      end
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p (8),
    .els_p   (stdout_els_p)
  ) stdout_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (w_accept & w_stdout_store),
    .data_i  (host_if.req_data_i[7:0]),
    .full_o  (w_fifo_full),
    .v_o     (char_v_o),
    .data_o  (char_o),
    .yumi_i  (char_v_o & char_ready_i)
  );

  assign host_if.resp_v_o      = r_resp_v;
  assign host_if.resp_load_o   = r_resp_load;
  assign host_if.resp_data_o   = r_resp_data;
  assign host_if.resp_reg_id_o = r_resp_reg_id;
  assign host_if.resp_dest_x_o = r_resp_dest_x;
  assign host_if.resp_dest_y_o = r_resp_dest_y;
  assign finish_v_o            = r_finish_v;
  assign fail_v_o              = r_fail_v;
  assign exit_data_o           = r_exit_data;
  assign err_o                 = r_err;

endmodule

// File: tb/tb_bsg_manycore_host_responder.sv
// Directed vector bench for the host responder: table of single requests plus
// hand sequences for stdout back-pressure, response stall and reset.
module tb_bsg_manycore_host_responder;

  localparam logic [16*32-1:0] ROM = {32'hF0F0_F0F0, {11{32'h0000_0000}},
                                      32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_0000};

  logic        clk, reset;
  logic        char_v, char_ready, finish_v, fail_v, err;
  logic [7:0]  char_d;
  logic [31:0] exit_data;

  int n_vec = 0;
  int n_bad = 0;

  bsg_manycore_host_responder_if #(.data_width_p(32), .addr_width_p(28), .x_cord_width_p(7),
                                   .y_cord_width_p(7), .reg_id_width_p(5)) bus ();

  bsg_manycore_host_responder #(
    .data_width_p(32), .addr_width_p(28), .x_cord_width_p(7), .y_cord_width_p(7),
    .reg_id_width_p(5), .rom_els_p(16), .rom_arr_p(ROM), .stdout_els_p(4)
  ) dut (
    .clk_i(clk), .reset_i(reset), .host_if(bus),
    .char_v_o(char_v), .char_o(char_d), .char_ready_i(char_ready),
    .finish_v_o(finish_v), .fail_v_o(fail_v), .exit_data_o(exit_data), .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [27:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [4:0]  rid;
    logic [6:0]  x;
    logic [6:0]  y;
    logic        e_load;
    logic [31:0] e_data;
    logic        e_fin;
    logic        e_fail;
    logic [31:0] e_exit;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [1:0] op, logic [27:0] addr, logic [31:0] data, logic [3:0] mask,
                              logic [4:0] rid, logic [6:0] x, logic [6:0] y, logic e_load,
                              logic [31:0] e_data, logic e_fin, logic e_fail, logic [31:0] e_exit,
                              logic e_err);
    vec_t v;
    v.op = op; v.addr = addr; v.data = data; v.mask = mask; v.rid = rid; v.x = x; v.y = y;
    v.e_load = e_load; v.e_data = e_data; v.e_fin = e_fin; v.e_fail = e_fail;
    v.e_exit = e_exit; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Drive one request and return just after the edge that accepts it.
  task automatic apply_req(input logic [1:0] op, input logic [27:0] addr, input logic [31:0] data,
                           input logic [3:0] mask, input logic [4:0] rid, input logic [6:0] x,
                           input logic [6:0] y, output bit ok);
    int n;
    bus.req_op_i = op; bus.req_addr_i = addr; bus.req_data_i = data; bus.req_mask_i = mask;
    bus.req_reg_id_i = rid; bus.req_src_x_i = x; bus.req_src_y_i = y; bus.req_v_i = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (n < 50);
    if (ok) begin
      @(posedge clk); #1;
    end
    bus.req_v_i = 1'b0;
  endtask

  initial begin
    bit        ok, accepted;
    int        n_chars, cyc;
    logic [39:0] got_chars;
    vec_t      v;

    reset = 1'b1; char_ready = 1'b0;
    bus.req_v_i = 1'b0; bus.req_op_i = 2'd0; bus.req_addr_i = 28'd0; bus.req_data_i = 32'd0;
    bus.req_mask_i = 4'd0; bus.req_reg_id_i = 5'd0; bus.req_src_x_i = 7'd0; bus.req_src_y_i = 7'd0;
    bus.resp_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("reset_state", 64'({bus.resp_v_o, char_v, finish_v, fail_v, err, exit_data, bus.req_ready_o}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1}));

    //            op    addr        data           mask  rid    x      y      load  data          fin   fail  exit         err
    vecs.push_back(mk(2'd0, 28'h3,    32'h0,         4'h0, 5'd7,  7'd2,  7'd5,  1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h0,    32'h0,         4'h0, 5'd1,  7'd1,  7'd1,  1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'hF,    32'h0,         4'h0, 5'd2,  7'd3,  7'd4,  1'b1, 32'hF0F0_F0F0, 1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h1003, 32'h0,         4'h0, 5'd3,  7'd0,  7'd6,  1'b1, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd1, 28'h1003, 32'hAABB_CCDD, 4'h5, 5'd4,  7'd9,  7'd8,  1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h1003, 32'h0,         4'h0, 5'd5,  7'd10, 7'd11, 1'b1, 32'h00BB_00DD, 1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd1, 28'h1003, 32'h1122_3344, 4'h0, 5'd6,  7'd12, 7'd13, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h1003, 32'h0,         4'h0, 5'd8,  7'd14, 7'd15, 1'b1, 32'h00BB_00DD, 1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd1, 28'h1003, 32'h1122_3344, 4'hA, 5'd9,  7'd16, 7'd17, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h1003, 32'h0,         4'h0, 5'd10, 7'd18, 7'd19, 1'b1, 32'h11BB_33DD, 1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd1, 28'h3,    32'hFFFF_FFFF, 4'hF, 5'd11, 7'd20, 7'd21, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h3,    32'h0,         4'h0, 5'd12, 7'd22, 7'd23, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h1000, 32'h0,         4'h0, 5'd13, 7'd24, 7'd25, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h1001, 32'h0,         4'h0, 5'd14, 7'd26, 7'd27, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd0, 28'h1002, 32'h0,         4'h0, 5'd15, 7'd28, 7'd29, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd1, 28'h1001, 32'h0,         4'hF, 5'd16, 7'd30, 7'd31, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0,       1'b0));
    vecs.push_back(mk(2'd1, 28'h1002, 32'h7,         4'hF, 5'd17, 7'd32, 7'd33, 1'b0, 32'h0,         1'b0, 1'b1, 32'h7,       1'b0));
    vecs.push_back(mk(2'd1, 28'h1001, 32'h55,        4'hF, 5'd18, 7'd34, 7'd35, 1'b0, 32'h0,         1'b1, 1'b0, 32'h55,      1'b0));
    vecs.push_back(mk(2'd0, 28'h2000, 32'h0,         4'h0, 5'd19, 7'd36, 7'd37, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd0, 28'h0,    32'h0,         4'h0, 5'd20, 7'd38, 7'd39, 1'b1, 32'hCAFE_0000, 1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd1, 28'h1003, 32'h0,         4'hF, 5'd21, 7'd40, 7'd41, 1'b0, 32'h0,         1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd0, 28'h1003, 32'h0,         4'h0, 5'd22, 7'd42, 7'd43, 1'b1, 32'h0,         1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd0, 28'h10,   32'h0,         4'h0, 5'd23, 7'd44, 7'd45, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd2, 28'h3,    32'h0,         4'h0, 5'd24, 7'd46, 7'd47, 1'b0, 32'h0,         1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd3, 28'h1003, 32'hFFFF_FFFF, 4'hF, 5'd25, 7'd48, 7'd49, 1'b0, 32'h0,         1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd0, 28'h1003, 32'h0,         4'h0, 5'd26, 7'd50, 7'd51, 1'b1, 32'h0,         1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd1, 28'h2000, 32'h1234,      4'hF, 5'd27, 7'd52, 7'd53, 1'b0, 32'h0,         1'b0, 1'b0, 32'h55,      1'b1));
    vecs.push_back(mk(2'd1, 28'h1002, 32'h9,         4'hF, 5'd28, 7'd54, 7'd55, 1'b0, 32'h0,         1'b0, 1'b1, 32'h9,       1'b1));
    vecs.push_back(mk(2'd0, 28'hF,    32'h0,         4'h0, 5'd29, 7'd56, 7'd57, 1'b1, 32'hF0F0_F0F0, 1'b0, 1'b0, 32'h9,       1'b1));
    vecs.push_back(mk(2'd0, 28'h3,    32'h0,         4'h0, 5'd30, 7'd58, 7'd59, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h9,       1'b1));
    vecs.push_back(mk(2'd0, 28'h1,    32'h0,         4'h0, 5'd31, 7'd60, 7'd61, 1'b1, 32'h0,         1'b0, 1'b0, 32'h9,       1'b1));
    vecs.push_back(mk(2'd0, 28'h2,    32'h0,         4'h0, 5'd0,  7'd62, 7'd63, 1'b1, 32'h0,         1'b0, 1'b0, 32'h9,       1'b1));
    vecs.push_back(mk(2'd0, 28'h1003, 32'h0,         4'h0, 5'd1,  7'd64, 7'd65, 1'b1, 32'h0,         1'b0, 1'b0, 32'h9,       1'b1));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      apply_req(v.op, v.addr, v.data, v.mask, v.rid, v.x, v.y, ok);
      check($sformatf("vec%0d_accept", i), 64'(ok), 64'(1'b1));
      check($sformatf("vec%0d_resp", i),
            64'({bus.resp_v_o, bus.resp_load_o, bus.resp_data_o, bus.resp_reg_id_o,
                 bus.resp_dest_x_o, bus.resp_dest_y_o, finish_v, fail_v, err}),
            64'({1'b1, v.e_load, v.e_data, v.rid, v.x, v.y, v.e_fin, v.e_fail, v.e_err}));
      check($sformatf("vec%0d_exit", i), 64'(exit_data), 64'(v.e_exit));
      @(posedge clk); #1;
      check($sformatf("vec%0d_after", i), 64'({bus.resp_v_o, finish_v, fail_v}), 64'(3'b000));
    end

    // stdout back-pressure: four chars fill the FIFO, the fifth stalls.
    char_ready = 1'b0;
    apply_req(2'd1, 28'h1000, 32'h61, 4'h1, 5'd0, 7'd1, 7'd1, ok);
    check("char_a_accept", 64'(ok), 64'(1'b1));
    check("char_first", 64'({char_v, char_d}), 64'({1'b1, 8'h61}));
    apply_req(2'd1, 28'h1000, 32'h62, 4'h1, 5'd0, 7'd1, 7'd1, ok);
    apply_req(2'd1, 28'h1000, 32'h63, 4'h1, 5'd0, 7'd1, 7'd1, ok);
    apply_req(2'd1, 28'h1000, 32'h64, 4'h1, 5'd0, 7'd1, 7'd1, ok);
    check("char_d_accept", 64'(ok), 64'(1'b1));
    bus.req_op_i = 2'd1; bus.req_addr_i = 28'h1000; bus.req_data_i = 32'h65; bus.req_v_i = 1'b1;
    #1;
    check("stdout_full_stall", 64'(bus.req_ready_o), 64'(1'b0));
    repeat (2) begin
      @(posedge clk); #1;
    end
    check("stdout_still_stalled", 64'({bus.req_ready_o, char_v, char_d}), 64'({1'b0, 1'b1, 8'h61}));
    char_ready = 1'b1;
    #1;
    n_chars = 0; got_chars = '0; accepted = 1'b0; cyc = 0;
    while (n_chars < 5 && cyc < 40) begin
      if (char_v) begin
        got_chars = {got_chars[31:0], char_d};
        n_chars++;
      end
      if (bus.req_v_i && bus.req_ready_o) accepted = 1'b1;
      @(posedge clk); #1;
      if (accepted) bus.req_v_i = 1'b0;
      #1;
      cyc++;
    end
    check("stdout_fifth_accepted", 64'(accepted), 64'(1'b1));
    check("stdout_order", 64'(got_chars), 64'(40'h61_62_63_64_65));
    bus.req_v_i = 1'b0;
    char_ready = 1'b0;
    @(posedge clk); #1;

    // Response stall with a queued request, then reset mid-transaction.
    apply_req(2'd1, 28'h1003, 32'h5A5A_5A5A, 4'hF, 5'd0, 7'd1, 7'd1, ok);
    apply_req(2'd1, 28'h1000, 32'h7A, 4'h1, 5'd0, 7'd1, 7'd1, ok);
    @(posedge clk); #1;
    bus.resp_ready_i = 1'b0;
    apply_req(2'd0, 28'h3, 32'h0, 4'h0, 5'd9, 7'd3, 7'd6, ok);
    check("stall_first_accept", 64'(ok), 64'(1'b1));
    bus.req_op_i = 2'd0; bus.req_addr_i = 28'h0; bus.req_reg_id_i = 5'd10; bus.req_v_i = 1'b1;
    #1;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_cycle%0d", c),
            64'({bus.resp_v_o, bus.resp_load_o, bus.resp_data_o, bus.resp_reg_id_o,
                 bus.resp_dest_x_o, bus.resp_dest_y_o, bus.req_ready_o}),
            64'({1'b1, 1'b1, 32'h1234_5678, 5'd9, 7'd3, 7'd6, 1'b0}));
      @(posedge clk); #1;
    end
    bus.req_v_i = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_mid_txn", 64'({bus.resp_v_o, char_v, finish_v, fail_v, err, exit_data}),
          64'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}));
    reset = 1'b0;
    bus.resp_ready_i = 1'b1;
    apply_req(2'd0, 28'h1003, 32'h0, 4'h0, 5'd11, 7'd4, 7'd2, ok);
    check("scratch_after_reset",
          64'({ok, bus.resp_v_o, bus.resp_load_o, bus.resp_data_o, bus.resp_reg_id_o, err}),
          64'({1'b1, 1'b1, 1'b1, 32'h0, 5'd11, 1'b0}));
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
